block_stats_accumulator: RTL and testbench

- Streams per-tile attention scores for two rows (lane 0, lane 1) and accumulates running min, max and sum, plus a tile count, across one block.
- Sits directly upstream of the block threshold calculator. Its registered min/max/sum/tile-count outputs drive that calculator's min0/max0/sum0, min1/max1/sum1 and noOfTiles inputs.
- Its stats_valid output drives the calculator's enable.

---
 rtl/block_stats_accumulator.sv | 135 +++++++++++++
 tb/tb_block_stats_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_stats_accumulator.sv
// Streams two lanes of tile scores per block and accumulates per-lane min/max/sum plus a tile count.
// Optional build macro BLOCK_STATS_SUM_SATURATE_EN clamps the sums instead of wrapping them.
module block_stats_accumulator #(
  parameter int width = 8,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [2*width-1:0]   score0,
  input  logic [2*width-1:0]   score1,
  output logic [2*width-1:0]   min0,
  output logic [2*width-1:0]   max0,
  output logic [2*width-1:0]   sum0,
  output logic [2*width-1:0]   min1,
  output logic [2*width-1:0]   max1,
  output logic [2*width-1:0]   sum1,
  output logic [CNT_W-1:0]     noOfTiles,
  output logic                 stats_valid,
  input  logic                 stats_ack,
  output logic                 cnt_ovf
);

  localparam int DW = 2 * width;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_stats_valid;
  logic             r_cnt_ovf;
  logic [DW-1:0]    r_min0, r_max0, r_sum0;
  logic [DW-1:0]    r_min1, r_max1, r_sum1;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  function automatic logic [DW-1:0] f_min(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [DW-1:0] f_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b > a) ? b : a;
  endfunction

  // Once clamped at all-ones, any further nonzero score carries again, so the clamp holds.
  function automatic logic [DW-1:0] f_sum(input logic [DW-1:0] acc, input logic [DW-1:0] s);
`ifdef BLOCK_STATS_SUM_SATURATE_EN
    logic [DW:0] t;
    t = {1'b0, acc} + {1'b0, s};
    return t[DW] ? {DW{1'b1}} : t[DW-1:0];
`else
    return acc + s;
`endif
  endfunction

  assign w_accept = in_valid & r_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b0;
      r_stats_valid <= 1'b0;
      r_cnt_ovf     <= 1'b0;
      r_min0        <= '1;
      r_max0        <= '0;
      r_sum0        <= '0;
      r_min1        <= '1;
      r_max1        <= '0;
      r_sum1        <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ACCUM;
            r_in_ready <= 1'b1;
            r_cnt_ovf  <= 1'b0;
            r_min0     <= '1;
            r_max0     <= '0;
            r_sum0     <= '0;
            r_min1     <= '1;
            r_max1     <= '0;
            r_sum1     <= '0;
            r_cnt      <= '0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_min0 <= f_min(r_min0, score0);
            r_max0 <= f_max(r_max0, score0);
            r_sum0 <= f_sum(r_sum0, score0);
            r_min1 <= f_min(r_min1, score1);
            r_max1 <= f_max(r_max1, score1);
            r_sum1 <= f_sum(r_sum1, score1);
            // Count sticks at its maximum; overflow flags only beats beyond that point.
            if (r_cnt == CNT_MAX) r_cnt_ovf <= 1'b1;
            else                  r_cnt     <= r_cnt + 1'b1;
            if (in_last) begin
              r_state       <= DONE;
              r_in_ready    <= 1'b0;
              r_stats_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (stats_ack) begin
            r_state       <= IDLE;
            r_stats_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_in_ready    <= 1'b0;
          r_stats_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign stats_valid = r_stats_valid;
  assign cnt_ovf     = r_cnt_ovf;
  assign min0        = r_min0;
  assign max0        = r_max0;
  assign sum0        = r_sum0;
  assign min1        = r_min1;
  assign max1        = r_max1;
  assign sum1        = r_sum1;
  assign noOfTiles   = r_cnt;

endmodule

// File: tb/tb_block_stats_accumulator.sv
// Directed bench for block_stats_accumulator: table of block vectors plus hand-written corner sequences.
module tb_block_stats_accumulator;

  localparam int WD = 8;
  localparam int DW = 2 * WD;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] score0 = '0;
  logic [DW-1:0] score1 = '0;
  logic          stats_ack = 1'b0;
  logic          in_ready, stats_valid, cnt_ovf;
  logic [DW-1:0] min0, max0, sum0, min1, max1, sum1;
  logic [CW-1:0] noOfTiles;

  int errors = 0;
  int checks = 0;

  block_stats_accumulator #(.width(WD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .score0(score0), .score1(score1),
    .min0(min0), .max0(max0), .sum0(sum0), .min1(min1), .max1(max1), .sum1(sum1),
    .noOfTiles(noOfTiles), .stats_valid(stats_valid), .stats_ack(stats_ack), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   n;
    logic [2:0][DW-1:0]   s0;
    logic [2:0][DW-1:0]   s1;
    int                   gap;
    int                   ackd;
    logic [DW-1:0]        emin0, emax0, esum0, emin1, emax1, esum1;
    logic [CW-1:0]        ecnt;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("in_ready_after_start", 32'(in_ready), 32'd1);
  endtask

  task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last, input int gap);
    in_valid = 1'b0;
    repeat (gap) cyc();
    in_valid = 1'b1;
    score0 = a;
    score1 = b;
    in_last = last;
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    chk("stats_valid_accum", 32'(stats_valid), 32'd0);
    cyc();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input vec_t v, input logic ovf);
    chk({tag, "_min0"}, 32'(min0), 32'(v.emin0));
    chk({tag, "_max0"}, 32'(max0), 32'(v.emax0));
    chk({tag, "_sum0"}, 32'(sum0), 32'(v.esum0));
    chk({tag, "_min1"}, 32'(min1), 32'(v.emin1));
    chk({tag, "_max1"}, 32'(max1), 32'(v.emax1));
    chk({tag, "_sum1"}, 32'(sum1), 32'(v.esum1));
    chk({tag, "_cnt"},  32'(noOfTiles), 32'(v.ecnt));
    chk({tag, "_ovf"},  32'(cnt_ovf), 32'(ovf));
  endtask

  task automatic ack_block();
    stats_ack = 1'b1;
    cyc();
    stats_ack = 1'b0;
    chk("stats_valid_after_ack", 32'(stats_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    string tag;

    tbl[0] = '{n:3, s0:{16'h0020, 16'h0005, 16'h0010}, s1:{16'h0080, 16'h0200, 16'h0100}, gap:0, ackd:0,
               emin0:16'h0005, emax0:16'h0020, esum0:16'h0035,
               emin1:16'h0080, emax1:16'h0200, esum1:16'h0380, ecnt:10'd3};
    tbl[1] = tbl[0];
    tbl[1].gap = 2;
    tbl[1].ackd = 5;
    tbl[2] = '{n:1, s0:{16'h0, 16'h0, 16'hABCD}, s1:{16'h0, 16'h0, 16'h0}, gap:0, ackd:1,
               emin0:16'hABCD, emax0:16'hABCD, esum0:16'hABCD,
               emin1:16'h0000, emax1:16'h0000, esum1:16'h0000, ecnt:10'd1};
`ifdef BLOCK_STATS_SUM_SATURATE_EN
    tbl[3] = '{n:2, s0:{16'h0, 16'h0020, 16'hFFF0}, s1:{16'h0, 16'h0002, 16'h0001}, gap:1, ackd:2,
               emin0:16'h0020, emax0:16'hFFF0, esum0:16'hFFFF,
               emin1:16'h0001, emax1:16'h0002, esum1:16'h0003, ecnt:10'd2};
`else
    tbl[3] = '{n:2, s0:{16'h0, 16'h0020, 16'hFFF0}, s1:{16'h0, 16'h0002, 16'h0001}, gap:1, ackd:2,
               emin0:16'h0020, emax0:16'hFFF0, esum0:16'h0010,
               emin1:16'h0001, emax1:16'h0002, esum1:16'h0003, ecnt:10'd2};
`endif

    // Reset state
    #12;
    v = '{n:0, s0:'0, s1:'0, gap:0, ackd:0, emin0:16'hFFFF, emax0:16'h0, esum0:16'h0,
          emin1:16'hFFFF, emax1:16'h0, esum1:16'h0, ecnt:10'd0};
    chk_stats("reset", v, 1'b0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_stats_valid", 32'(stats_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Count saturation: 1030 beats
    start_block();
    for (int i = 0; i < 1030; i++) begin
      beat(16'd1, 16'd2, (i == 1029), 0);
      if (i == 1022) begin
        chk("cnt_at_max", 32'(noOfTiles), 32'd1023);
        chk("ovf_not_yet", 32'(cnt_ovf), 32'd0);
      end
      if (i == 1023) chk("ovf_first_extra", 32'(cnt_ovf), 32'd1);
    end
    v = '{n:0, s0:'0, s1:'0, gap:0, ackd:0, emin0:16'd1, emax0:16'd1, esum0:16'd1030,
          emin1:16'd2, emax1:16'd2, esum1:16'd2060, ecnt:10'd1023};
    chk("sat_stats_valid", 32'(stats_valid), 32'd1);
    chk_stats("sat", v, 1'b1);
    ack_block();
    cyc();

    // Table-driven blocks (also confirms cnt_ovf is cleared by the next start)
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("vec%0d", i);
      start_block();
      for (int b = 0; b < tbl[i].n; b++)
        beat(tbl[i].s0[b], tbl[i].s1[b], (b == tbl[i].n - 1), (b == 0) ? 0 : tbl[i].gap);
      chk({tag, "_valid_latency"}, 32'(stats_valid), 32'd1);
      for (int c = 0; c < tbl[i].ackd; c++) begin
        chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_hold_valid"}, 32'(stats_valid), 32'd1);
        chk_stats({tag, "_hold"}, tbl[i], 1'b0);
        cyc();
      end
      chk_stats(tag, tbl[i], 1'b0);
      ack_block();
      chk({tag, "_post_ack_sum0"}, 32'(sum0), 32'(tbl[i].esum0));
      cyc();
    end

    // start ignored in ACCUM and DONE; start+ack in DONE drops the start
    start_block();
    beat(16'h0055, 16'h0066, 1'b0, 0);
    start = 1'b1;
    beat(16'h0011, 16'h0077, 1'b1, 0);
    start = 1'b0;
    v = '{n:0, s0:'0, s1:'0, gap:0, ackd:0, emin0:16'h0011, emax0:16'h0055, esum0:16'h0066,
          emin1:16'h0066, emax1:16'h0077, esum1:16'h00DD, ecnt:10'd2};
    chk_stats("start_in_accum", v, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_in_done_valid", 32'(stats_valid), 32'd1);
    chk("start_in_done_ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    stats_ack = 1'b1;
    cyc();
    start = 1'b0;
    stats_ack = 1'b0;
    chk("start_ack_valid", 32'(stats_valid), 32'd0);
    cyc();
    chk("start_ack_dropped", 32'(in_ready), 32'd0);
    chk_stats("start_ack_held", v, 1'b0);

    // Reset mid-block
    start_block();
    beat(16'd3, 16'd4, 1'b0, 0);
    beat(16'd5, 16'd6, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    v = '{n:0, s0:'0, s1:'0, gap:0, ackd:0, emin0:16'hFFFF, emax0:16'h0, esum0:16'h0,
          emin1:16'hFFFF, emax1:16'h0, esum1:16'h0, ecnt:10'd0};
    chk_stats("midrst", v, 1'b0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    start_block();
    beat(16'd7, 16'd0, 1'b1, 0);
    v = '{n:0, s0:'0, s1:'0, gap:0, ackd:0, emin0:16'd7, emax0:16'd7, esum0:16'd7,
          emin1:16'd0, emax1:16'd0, esum1:16'd0, ecnt:10'd1};
    chk("midrst_valid", 32'(stats_valid), 32'd1);
    chk_stats("after_rst", v, 1'b0);
    ack_block();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
